// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LogicNets layer: one shared truth-table RAM, neurons evaluated one per cycle
// through a run-time connectivity table, results assembled into a registered output vector.
module lut_layer_sequencer #(
    parameter int IN_ACTS  = 32,
    parameter int NEURONS  = 16,
    parameter int FAN_IN   = 4,
    parameter int ACT_BITS = 2,
    parameter int OUT_BITS = 2,
    localparam int AB = FAN_IN * ACT_BITS,
    localparam int NB = $clog2(NEURONS),
    localparam int IB = $clog2(IN_ACTS),
    localparam int FB = $clog2(FAN_IN),
    localparam int WB = (OUT_BITS > IB) ? OUT_BITS : IB
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_ACTS*ACT_BITS-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_data,
    input  logic                         cfg_we,
    input  logic                         cfg_sel,
    input  logic [NB+AB-1:0]             cfg_addr,
    input  logic [WB-1:0]                cfg_wdata,
    output logic                         cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                            state_r;
    state_t                            state_s;
    logic [IN_ACTS*ACT_BITS-1:0]       in_reg_r;
    logic [NEURONS*FAN_IN-1:0][IB-1:0] conn_r;
    logic [NB-1:0]                     cnt_r;
    logic [NB-1:0]                     pend_idx_r;
    logic                              drain_r;
    logic                              pend_r;
    logic [NEURONS*OUT_BITS-1:0]       out_data_r;
    logic                              cfg_err_r;
    logic [OUT_BITS-1:0]               tt_mem [NEURONS*(2**AB)];
    logic [OUT_BITS-1:0]               rd_data_r;
    logic [AB-1:0]                     lut_addr_s;
    logic                              issue_s;
    logic                              cfg_ok_s;
    logic                              tt_we_s;

    // drain_r marks the extra cycle after the counter wrap that captures the last read
    assign issue_s  = (state_r == EVAL) && !drain_r;
    assign cfg_ok_s = cfg_we && (state_r == IDLE) && !in_valid;
    assign tt_we_s  = cfg_ok_s && !cfg_sel;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = EVAL;
                else          state_s = IDLE;
            end
            EVAL: begin
                if (drain_r) state_s = DONE;
                else         state_s = EVAL;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Gather the current neuron's activations into its truth-table address
    always_comb begin
        lut_addr_s = '0;
        for (int k = 0; k < FAN_IN; k++) begin
            lut_addr_s[k*ACT_BITS +: ACT_BITS] =
                in_reg_r[conn_r[{cnt_r, FB'(k)}]*ACT_BITS +: ACT_BITS];
        end
    end

    // Shared truth-table RAM; contents survive reset
    always_ff @(posedge clk) begin
        if (tt_we_s) tt_mem[cfg_addr] <= cfg_wdata[OUT_BITS-1:0];
        rd_data_r <= tt_mem[{cnt_r, lut_addr_s}];
    end

    // Input latch, neuron counter, connectivity writes and write rejection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg_r  <= '0;
            conn_r    <= '0;
            cnt_r     <= '0;
            drain_r   <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we && !cfg_ok_s;
            if (cfg_ok_s && cfg_sel) conn_r[cfg_addr[NB+FB-1:0]] <= cfg_wdata[IB-1:0];
            if ((state_r == IDLE) && in_valid) begin
                in_reg_r <= in_data;
                cnt_r    <= '0;
                drain_r  <= 1'b0;
            end else if (issue_s) begin
                cnt_r <= cnt_r + 1'b1;
                if (cnt_r == NB'(NEURONS - 1)) drain_r <= 1'b1;
            end
        end
    end

    // Capture RAM data one cycle after its read was issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= 1'b0;
            pend_idx_r <= '0;
            out_data_r <= '0;
        end else begin
            pend_r     <= issue_s;
            pend_idx_r <= cnt_r;
            if (pend_r) out_data_r[pend_idx_r*OUT_BITS +: OUT_BITS] <= rd_data_r;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign out_data  = out_data_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Scoreboard bench for lut_layer_sequencer: stimulus pushes expected vectors and accept times,
// a negedge monitor pops and compares data and latency when out_valid rises.
module tb_lut_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        cfg_we;
    logic        cfg_sel;
    logic [11:0] cfg_addr;
    logic [4:0]  cfg_wdata;
    logic        cfg_err;

    lut_layer_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        int          e0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_it;
    bit   seen = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    localparam logic [31:0] ALL_N  = 32'hE4E4E4E4;
    localparam logic [31:0] HIT_N0 = 32'hE4E4E4E7;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Monitor: compare each result the first cycle out_valid is seen high
    always @(negedge clk) begin
        if (!rst_n || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got %0h, expected no result", out_data);
            end else begin
                mon_it = exp_q.pop_front();
                check("out_data", out_data, mon_it.d);
                check("latency", 32'(cyc - mon_it.e0), 32'd17);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic sel, input logic [11:0] addr, input logic [4:0] data);
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start_vec(input logic [63:0] data, input bit push, input logic [31:0] want);
        in_data  = data;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        if (!in_ready) begin
            n_chk++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        tick();
        if (push) exp_q.push_back('{want, cyc});
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid || !in_ready); i++) tick();
        if (exp_q.size() != 0 || out_valid || !in_ready) begin
            n_chk++;
            $display("FAIL idle_timeout: got pending=%0d, expected 0", exp_q.size());
        end
    endtask

    function automatic logic [63:0] mkvec(input logic [1:0] a5, input logic [1:0] a9,
                                          input logic [1:0] a1, input logic [1:0] a30);
        logic [63:0] v;
        v = 64'h5555_5555_5555_5555;
        v[10 +: 2] = a5;
        v[18 +: 2] = a9;
        v[2  +: 2] = a1;
        v[60 +: 2] = a30;
        return v;
    endfunction

    task automatic program_conn0();
        cfg_write(1'b1, 12'd0, 5'd5);
        cfg_write(1'b1, 12'd1, 5'd9);
        cfg_write(1'b1, 12'd2, 5'd1);
        cfg_write(1'b1, 12'd3, 5'd30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] va;
        logic [63:0] vb;
        va = mkvec(2'd0, 2'd2, 2'd3, 2'd0);
        vb = mkvec(2'd0, 2'd2, 2'd3, 2'd1);
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Neuron n returns n[1:0] everywhere; neuron 0 returns 0 except at 8'h38
        for (int n = 0; n < 16; n++) begin
            for (int a = 0; a < 256; a++) begin
                cfg_write(1'b0, 12'(n * 256 + a), (n == 0) ? 5'd0 : 5'(n % 4));
            end
        end
        cfg_write(1'b0, 12'h038, 5'd3);
        program_conn0();
        check("legal_write_no_err", 32'(cfg_err), 32'd0);

        // Single neuron lookup: hit, then miss with act30 = 1
        start_vec(va, 1'b1, HIT_N0);
        wait_idle();
        start_vec(vb, 1'b1, ALL_N);
        wait_idle();

        // Backpressure in DONE with a new vector waiting
        out_ready = 1'b0;
        start_vec(va, 1'b1, HIT_N0);
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        in_data  = vb;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", out_data, HIT_N0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_out_valid", 32'(out_valid), 32'd0);
        tick();
        exp_q.push_back('{ALL_N, cyc});
        in_valid = 1'b0;
        check("bp_accept", 32'(in_ready), 32'd0);
        wait_idle();

        // Truth-table write to neuron 3 during EVAL is dropped
        start_vec(64'd0, 1'b1, ALL_N);
        tick();
        tick();
        cfg_write(1'b0, 12'h300, 5'd0);
        check("eval_cfg_err", 32'(cfg_err), 32'd1);
        tick();
        check("eval_cfg_err_pulse", 32'(cfg_err), 32'd0);
        wait_idle();
        // Write together with in_valid in IDLE is also dropped
        cfg_sel = 1'b0; cfg_addr = 12'h300; cfg_wdata = 5'd0; cfg_we = 1'b1;
        in_data = 64'd0; in_valid = 1'b1;
        tick();
        exp_q.push_back('{ALL_N, cyc});
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check("idle_valid_cfg_err", 32'(cfg_err), 32'd1);
        wait_idle();

        // Reset while neuron 7 is being read
        start_vec(va, 1'b0, 32'd0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("in_rst_out_valid", 32'(out_valid), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        // Connectivity cleared: neuron 0 reads act0 = 1 four times, address 8'h55
        start_vec(va, 1'b1, ALL_N);
        wait_idle();
        program_conn0();
        start_vec(va, 1'b1, HIT_N0);
        wait_idle();

        // Full layer: neuron 0 now returns 0 everywhere
        cfg_write(1'b0, 12'h038, 5'd0);
        start_vec(va, 1'b1, ALL_N);
        wait_idle();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lut_layer_sequencer.md
# lut_layer_sequencer

Time-multiplexed evaluator for one LogicNets layer. One truth-table memory is shared by all neurons, and the block sequences the neurons through it one per cycle. For each neuron it gathers the neuron's FAN_IN activations from a latched input vector through a run-time connectivity table, looks up the neuron's truth table, and assembles the layer output vector. It is used where a layer is too large to unroll into per-neuron LUT ROMs, and it sits between adjacent layers behind valid/ready handshakes.

## Interface
- IN_ACTS, 32, number of input activations; must be a power of two.
- NEURONS, 16, neurons in the layer; must be a power of two and at least 2.
- FAN_IN, 4, inputs per neuron.
- ACT_BITS, 2, bits per input activation.
- OUT_BITS, 2, bits per neuron output.
- Derived widths:
  - AB = FAN_IN*ACT_BITS (8)
  - NB = log2(NEURONS)
  - IB = log2(IN_ACTS)
  - WB = max(OUT_BITS, IB)
- Ports:
  - clk  in  1  sole clock; all state on rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - in_valid  in  1  input vector valid.
  - in_ready  out  1  block accepts an input vector.
  - in_data  in  IN_ACTS*ACT_BITS  activation i at [i*ACT_BITS +: ACT_BITS].
  - out_valid  out  1  layer result valid.
  - out_ready  in  1  downstream accepts the result.
  - out_data  out  NEURONS*OUT_BITS  neuron n output at [n*OUT_BITS +: OUT_BITS].
  - cfg_we  in  1  configuration write strobe.
  - cfg_sel  in  1  0 = truth table, 1 = connectivity.
  - cfg_addr  in  NB+AB  truth table: {neuron, lut_addr}; connectivity: {neuron, slot} in the low NB+log2(FAN_IN) bits, upper bits ignored.
  - cfg_wdata  in  WB  truth table: low OUT_BITS bits; connectivity: low IB bits = input index.
  - cfg_err  out  1  one-cycle pulse when a write is rejected.

## Operation
- Storage:
  - Truth-table RAM: NEURONS*2^AB entries of OUT_BITS, synchronous read with 1-cycle latency, not reset.
  - Connectivity registers: NEURONS*FAN_IN entries of IB bits, reset to 0.
- LUT address for neuron n: slot k contributes activation in_reg[conn[n][k]] at address bits [k*ACT_BITS +: ACT_BITS].
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch in_data into in_reg, set neuron counter = 0, go to EVAL.
  - cfg_we is honoured only in IDLE and only when in_valid is low.
  - A write takes effect at the edge and is visible to the next evaluation.
- EVAL:
  - On cycle j (j = 0..NEURONS-1), issue the read for neuron j.
  - On cycle j+1, capture the RAM data into out_data[j*OUT_BITS +: OUT_BITS].
  - After the capture for neuron NEURONS-1, go to DONE.
  - The counter wraps to 0 after NEURONS-1, and the wrap is the exit condition.
- DONE:
  - out_valid = 1.
  - On out_ready, go to IDLE.
  - out_data holds its value until overwritten by the next evaluation.
- No overlap: in_ready = 0 in EVAL and DONE, and in_data is ignored there.
- Rejected write: cfg_we in EVAL or DONE, or in IDLE together with in_valid. The write is dropped, cfg_err pulses for 1 cycle, and the FSM is unaffected.
- Reset (asynchronous assert, at any time including mid-EVAL):
  - FSM = IDLE, out_valid = 0, out_data = 0, cfg_err = 0, counter = 0, connectivity = 0, in_reg = 0.
  - Truth-table contents are retained.
  - in_ready = 1 in the first cycle after deassertion.
- out_valid, in_ready and cfg_err are registered or decoded from FSM state only. There is no combinational path from in_valid or out_ready to any output.

## Timing
- Let the accepting edge be E0.
- out_valid rises at edge E0+NEURONS+1.
- Earliest output handshake is at edge E0+NEURONS+2, with in_ready high again after it.
- Steady-state throughput with in_valid and out_ready held at 1: one vector per NEURONS+3 cycles.
- A configuration write occupies 1 cycle.
- cfg_err asserts on the edge following the rejected strobe.

## Test plan
- **Reset values:** assert rst_n = 0 mid-simulation -> in_ready = 1, out_valid = 0, out_data = 0, cfg_err = 0.
- **Single neuron lookup:**
  - Stimulus: program neuron 0 connectivity slots 0..3 = {5, 9, 1, 30}; truth-table entry {0, 8'h38} = 2'b11, all other neuron-0 entries = 0; in_data with act5 = 0, act9 = 2, act1 = 3, act30 = 0 (address 8'b00111000).
  - Response: out_valid at exactly E0+17 with out_data[1:0] = 2'b11.
  - Repeat with act30 = 1 -> out_data[1:0] = 2'b00.
- **Full layer:** program the truth table of neuron n to return n[1:0] for every address -> out_data = 32'hE4E4E4E4.
- **Backpressure:**
  - Stimulus: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1.
  - Response: out_valid and out_data stable, in_ready = 0.
  - After the out_ready handshake, a new vector is accepted on the following edge.
- **Config during EVAL:**
  - Stimulus: cfg_we targeting neuron 3 during EVAL.
  - Response: cfg_err pulses for 1 cycle, the write is dropped, and re-running the same vector gives an identical out_data.
- **Reset mid-EVAL:**
  - Stimulus: assert rst_n at neuron 7; reprogram connectivity only; resend the vector.
  - Response: out_valid stays 0 through reset, and the result matches the fault-free reference using the retained truth table.
